// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard unit
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_scoreboard.sv
// rtl/mdu_scoreboard.sv - per-register busy scoreboard and MDU latency FSM
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RW      = $clog2(NREG),
    parameter int MDU_LAT = 8,
    parameter int CW      = $clog2(MDU_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [RW-1:0] writeregD,
    input  logic          regwriteD,
    input  logic          mduD,
    input  logic [RW-1:0] writeregE,
    input  logic          mdu_startE,
    input  logic          predict_wrong,
    input  logic          regwriteW,
    output logic          rawstall,
    output logic          wawstall,
    output logic          structstall,
    output logic          mdu_wb,
    output logic [RW-1:0] mdu_wb_reg,
    output logic          mdu_busy
);

    mdu_state_t      state;
    logic [CW-1:0]   cnt;
    logic [NREG-1:0] busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= '0;
            mdu_wb_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_startE && !predict_wrong) begin
                        cnt        <= CW'(MDU_LAT - 1);
                        mdu_wb_reg <= writeregE;
                        if (writeregE != '0)
                            busy[writeregE] <= 1'b1;
                        state <= BUSY;
                    end
                end
                // Leave BUSY one count early so WB lands MDU_LAT cycles after issue;
                // MDU_LAT=1 still spends its single BUSY cycle.
                BUSY: begin
                    if (cnt == '0 || cnt == CW'(1))
                        state <= WB;
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                end
                WB: begin
                    if (!regwriteW) begin
                        busy[mdu_wb_reg] <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mdu_busy    = (state != IDLE);
    assign mdu_wb      = (state == WB) && !regwriteW;
    assign rawstall    = ((rsD != '0) && busy[rsD]) || ((rtD != '0) && busy[rtD]);
    assign wawstall    = regwriteD && (writeregD != '0) && busy[writeregD];
    assign structstall = mduD && ((state != IDLE) || mdu_startE);

endmodule

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - 5-stage hazard unit: forwarding, stalls, flushes, MDU write-back grant
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RW      = $clog2(NREG),
    parameter int MDU_LAT = 8,
    parameter int CW      = $clog2(MDU_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [RW-1:0] writeregD,
    input  logic          regwriteD,
    input  logic          mduD,
    input  logic [RW-1:0] rsE,
    input  logic [RW-1:0] rtE,
    input  logic [RW-1:0] writeregE,
    input  logic          regwriteE,
    input  logic          memtoregE,
    input  logic          mdu_startE,
    input  logic [RW-1:0] writeregM,
    input  logic [RW-1:0] writeregW,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          predict_wrong,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          stallF,
    output logic          stallD,
    output logic          flushD,
    output logic          flushE,
    output logic          mdu_wb,
    output logic [RW-1:0] mdu_wb_reg,
    output logic          mdu_busy
);

    logic       lwstall, rawstall, wawstall, structstall, stall;
    logic       sb_wb, sb_busy;
    logic [1:0] fwd_a, fwd_b;
    logic       unused_regwrite_e;

    assign unused_regwrite_e = regwriteE;

    mdu_scoreboard #(
        .NREG(NREG), .RW(RW), .MDU_LAT(MDU_LAT), .CW(CW)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .rsD          (rsD),
        .rtD          (rtD),
        .writeregD    (writeregD),
        .regwriteD    (regwriteD),
        .mduD         (mduD),
        .writeregE    (writeregE),
        .mdu_startE   (mdu_startE),
        .predict_wrong(predict_wrong),
        .regwriteW    (regwriteW),
        .rawstall     (rawstall),
        .wawstall     (wawstall),
        .structstall  (structstall),
        .mdu_wb       (sb_wb),
        .mdu_wb_reg   (mdu_wb_reg),
        .mdu_busy     (sb_busy)
    );

    always_comb begin
        fwd_a = FWD_NONE;
        if (rsE != '0 && rsE == writeregM && regwriteM)
            fwd_a = FWD_M;
        else if (rsE != '0 && rsE == writeregW && regwriteW)
            fwd_a = FWD_W;

        fwd_b = FWD_NONE;
        if (rtE != '0 && rtE == writeregM && regwriteM)
            fwd_b = FWD_M;
        else if (rtE != '0 && rtE == writeregW && regwriteW)
            fwd_b = FWD_W;
    end

    assign lwstall = memtoregE && (writeregE != '0) && (rsD == writeregE || rtD == writeregE);
    assign stall   = lwstall || rawstall || wawstall || structstall;

    // Everything reads as quiet while reset is held, even with live pipeline inputs.
    always_comb begin
        forwardAE = rst ? FWD_NONE : fwd_a;
        forwardBE = rst ? FWD_NONE : fwd_b;
        stallF    = !rst && stall && !predict_wrong;
        stallD    = !rst && stall && !predict_wrong;
        flushD    = !rst && predict_wrong;
        flushE    = !rst && (predict_wrong || stall);
        mdu_wb    = !rst && sb_wb;
        mdu_busy  = !rst && sb_busy;
    end

endmodule

// File: tb/tb_hazard_sb.sv
// tb/tb_hazard_sb.sv - self-checking bench for hazard_sb with a timeline-based reference model
module tb_hazard_sb;

    localparam int NREG   = 32;
    localparam int RW     = 5;
    localparam int LAT    = 4;
    localparam int CW     = $clog2(LAT + 1);
    localparam int WB_OFF = (LAT < 2) ? 2 : LAT;

    logic          clk, rst;
    logic [RW-1:0] rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteD, mduD, regwriteE, memtoregE, mdu_startE;
    logic          regwriteM, regwriteW, predict_wrong;
    logic [1:0]    forwardAE, forwardBE;
    logic          stallF, stallD, flushD, flushE, mdu_wb, mdu_busy;
    logic [RW-1:0] mdu_wb_reg;

    int checks = 0;
    int errors = 0;

    hazard_sb #(.NREG(NREG), .RW(RW), .MDU_LAT(LAT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .writeregD(writeregD), .regwriteD(regwriteD), .mduD(mduD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .mdu_startE(mdu_startE),
        .writeregM(writeregM), .writeregW(writeregW),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .predict_wrong(predict_wrong),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .mdu_wb(mdu_wb), .mdu_wb_reg(mdu_wb_reg), .mdu_busy(mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding MDU op described by its issue cycle and destination.
    bit mbusy [NREG];
    bit m_active;
    int m_issue, m_dest, m_last;
    int cyc = 0;

    function automatic logic [1:0] fwd_exp(input int r, input int dm, input bit wm,
                                           input int dw, input bit ww);
        if (r != 0 && r == dm && wm) return 2'b10;
        if (r != 0 && r == dw && ww) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        bit lw, raw, waw, st, stl, inwb, wbx;
        if (rst) begin
            chk("rst_fwdA", forwardAE, 0);
            chk("rst_fwdB", forwardBE, 0);
            chk("rst_stallF", stallF, 0);
            chk("rst_stallD", stallD, 0);
            chk("rst_flushD", flushD, 0);
            chk("rst_flushE", flushE, 0);
            chk("rst_wb", mdu_wb, 0);
            chk("rst_wbreg", mdu_wb_reg, 0);
            chk("rst_busy", mdu_busy, 0);
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_active = 1'b0;
            m_last   = 0;
        end else begin
            lw   = memtoregE && writeregE != 0 && (rsD == writeregE || rtD == writeregE);
            raw  = (rsD != 0 && mbusy[rsD]) || (rtD != 0 && mbusy[rtD]);
            waw  = regwriteD && writeregD != 0 && mbusy[writeregD];
            st   = mduD && (m_active || mdu_startE);
            stl  = lw || raw || waw || st;
            inwb = m_active && (cyc >= m_issue + WB_OFF);
            wbx  = inwb && !regwriteW;
            chk("fwdA", forwardAE, fwd_exp(rsE, writeregM, regwriteM, writeregW, regwriteW));
            chk("fwdB", forwardBE, fwd_exp(rtE, writeregM, regwriteM, writeregW, regwriteW));
            chk("stallF", stallF, stl && !predict_wrong);
            chk("stallD", stallD, stl && !predict_wrong);
            chk("flushD", flushD, predict_wrong);
            chk("flushE", flushE, predict_wrong || stl);
            chk("mdu_wb", mdu_wb, wbx);
            chk("mdu_wb_reg", mdu_wb_reg, m_last);
            chk("mdu_busy", mdu_busy, m_active);
            if (wbx) begin
                mbusy[m_dest] = 1'b0;
                m_active = 1'b0;
            end else if (!m_active && mdu_startE && !predict_wrong) begin
                m_active = 1'b1;
                m_issue  = cyc;
                m_dest   = writeregE;
                m_last   = writeregE;
                if (m_dest != 0) mbusy[m_dest] = 1'b1;
            end
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        {rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteD, mduD, regwriteE, memtoregE, mdu_startE} = '0;
        {regwriteM, regwriteW, predict_wrong} = '0;
    endtask

    function automatic logic [RW-1:0] ridx();
        return ($urandom_range(0, 3) == 0) ? RW'($urandom_range(0, NREG - 1))
                                           : RW'($urandom_range(0, 7));
    endfunction

    initial begin
        quiet();
        rst = 1'b1;
        rsE = 5; writeregM = 5; regwriteM = 1'b1;
        smp();
        chk("lit_reset_fwdA", forwardAE, 2'b00);
        chk("lit_reset_busy", mdu_busy, 0);
        chk("lit_reset_wbreg", mdu_wb_reg, 0);
        nxt(); rst = 1'b0; quiet();

        nxt(); rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
        smp(); chk("lit_fwdA_M", forwardAE, 2'b10);
        nxt(); rsE = 0;
        smp(); chk("lit_fwdA_r0", forwardAE, 2'b00);
        nxt(); rtE = 5; regwriteM = 0;
        smp(); chk("lit_fwdB_W", forwardBE, 2'b01);

        nxt(); quiet(); memtoregE = 1; writeregE = 7; rtD = 7;
        smp();
        chk("lit_lw_stallF", stallF, 1);
        chk("lit_lw_stallD", stallD, 1);
        chk("lit_lw_flushE", flushE, 1);
        chk("lit_lw_flushD", flushD, 0);
        nxt(); predict_wrong = 1;
        smp();
        chk("lit_pw_stallF", stallF, 0);
        chk("lit_pw_flushD", flushD, 1);
        chk("lit_pw_flushE", flushE, 1);

        nxt(); quiet(); mdu_startE = 1; writeregE = 9; rsD = 9;
        smp(); chk("lit_mdu_c0_stallD", stallD, 0);
        for (int k = 1; k <= 6; k++) begin
            nxt(); mdu_startE = 0; writeregE = 0;
            smp();
            chk("lit_mdu_stallD", stallD, (k <= 4));
            chk("lit_mdu_wb", mdu_wb, (k == 4));
            if (k == 4) chk("lit_mdu_wbreg", mdu_wb_reg, 9);
        end

        nxt(); quiet(); mdu_startE = 1; writeregE = 9; rsD = 9; writeregW = 3;
        for (int k = 1; k <= 8; k++) begin
            nxt(); mdu_startE = 0; writeregE = 0; regwriteW = (k == 4 || k == 5);
            smp();
            chk("lit_dly_stallD", stallD, (k <= 6));
            chk("lit_dly_wb", mdu_wb, (k == 6));
        end

        nxt(); quiet(); mdu_startE = 1; writeregE = 12;
        for (int k = 1; k <= 6; k++) begin
            nxt(); mduD = 1; mdu_startE = (k == 2); writeregE = (k == 2) ? 5'd13 : 5'd0;
            smp();
            chk("lit_struct_stallD", stallD, (k <= 4));
            if (k == 3 || k == 4) chk("lit_struct_wbreg", mdu_wb_reg, 12);
            if (k == 4) chk("lit_struct_wb", mdu_wb, 1);
        end

        nxt(); quiet(); mdu_startE = 1; writeregE = 20; rsD = 20;
        nxt(); mdu_startE = 0; writeregE = 0;
        smp();
        chk("lit_pre_rst_stallD", stallD, 1);
        chk("lit_pre_rst_busy", mdu_busy, 1);
        nxt(); rst = 1;
        smp();
        chk("lit_rst_busy", mdu_busy, 0);
        chk("lit_rst_stallD", stallD, 0);
        chk("lit_rst_stallF", stallF, 0);
        chk("lit_rst_flushE", flushE, 0);
        nxt(); rst = 0;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("lit_post_rst_wb", mdu_wb, 0);
            chk("lit_post_rst_stallD", stallD, 0);
            nxt();
        end

        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst           = ($urandom_range(0, 299) == 0);
            rsD           = ridx();
            rtD           = ridx();
            writeregD     = ridx();
            regwriteD     = $urandom_range(0, 1);
            mduD          = ($urandom_range(0, 5) == 0);
            rsE           = ridx();
            rtE           = ridx();
            writeregE     = ridx();
            regwriteE     = $urandom_range(0, 1);
            memtoregE     = ($urandom_range(0, 3) == 0);
            mdu_startE    = ($urandom_range(0, 7) == 0);
            writeregM     = ridx();
            writeregW     = ridx();
            regwriteM     = $urandom_range(0, 1);
            regwriteW     = ($urandom_range(0, 2) == 0);
            predict_wrong = ($urandom_range(0, 15) == 0);
        end

        nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
